nav_map_checker: RTL and testbench

Produces the walk/climb permission flags consumed by the chef movement block, the other end of that interface. Once per frame it reads the chef's tile and the tile below from the level map ROM. It then decides whether horizontal walking and vertical climbing are legal. It sits between the chef block, the level map ROM and the frame timing, in the Clk domain.

---
 rtl/nav_pkg.sv | 18 +
 rtl/frame_edge_detect.sv | 28 ++
 rtl/nav_map_checker.sv | 119 +++++++++++
 tb/tb_nav_map_checker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nav_pkg.sv
// Shared constants and state encoding for the level-map walk/climb checker.
package nav_pkg;

  localparam int unsigned TILE_FLOOR_BIT   = 0;
  localparam int unsigned TILE_LADDER_BIT  = 1;
  localparam int unsigned TILE_W           = 2;
  localparam int unsigned COORD_W          = 10;
  localparam int unsigned MAP_LOG2_DEFAULT = 5;
  localparam int unsigned MAP_ADDR_W       = 2 * MAP_LOG2_DEFAULT;

  typedef enum logic [1:0] {
    IDLE,
    RD_CUR,
    RD_BELOW,
    RESOLVE
  } nav_state_e;

endpackage

// File: rtl/frame_edge_detect.sv
// Brings the asynchronous frame tick into the Clk domain and emits a registered
// one-cycle pulse on each rising edge.
module frame_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic async_in,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic sync2_prev;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync2_prev <= 1'b0;
      pulse      <= 1'b0;
    end else begin
      sync1      <= async_in;
      sync2      <= sync1;
      sync2_prev <= sync2;
      pulse      <= sync2 & ~sync2_prev;
    end
  end

endmodule

// File: rtl/nav_map_checker.sv
// Once per frame, reads the chef's tile and the tile below from the map ROM and
// decides whether walking and climbing are currently allowed.
module nav_map_checker
  import nav_pkg::*;
#(
  parameter int unsigned         TILE_SHIFT  = 3,
  parameter int unsigned         MAP_LOG2    = MAP_LOG2_DEFAULT,
  parameter logic [2:0]          WALK_ALIGN  = 3'd0,
  parameter logic [2:0]          CLIMB_ALIGN = 3'd0,
  parameter logic [COORD_W-1:0]  X_LIMIT     = 10'd192,
  parameter logic [COORD_W-1:0]  Y_LIMIT     = 10'd148
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic [COORD_W-1:0]      ChefX,
  input  logic [COORD_W-1:0]      ChefY,
  output logic [2*MAP_LOG2-1:0]   map_addr,
  output logic                    map_rd,
  input  logic [TILE_W-1:0]       map_data,
  output logic                    walk,
  output logic                    climb,
  output logic                    busy
);

  typedef logic [MAP_LOG2-1:0] idx_t;

  logic edge_pulse;

  frame_edge_detect u_frame_edge_detect (
    .Clk      (Clk),
    .Reset    (Reset),
    .async_in (frame_clk),
    .pulse    (edge_pulse)
  );

  nav_state_e         state;
  logic [COORD_W-1:0] chef_x_snap;
  logic [COORD_W-1:0] chef_y_snap;
  idx_t               row_snap;
  idx_t               col_snap;
  logic [TILE_W-1:0]  cur_tile;

  idx_t row_now;
  idx_t col_now;
  idx_t row_below;
  logic last_row;
  logic out_of_range;
  logic below_ladder;
  logic walk_next;
  logic climb_next;

  always_comb begin
    row_now   = idx_t'(ChefY >> TILE_SHIFT);
    col_now   = idx_t'(ChefX >> TILE_SHIFT);
    last_row  = (row_snap == '1);
    // The bottom row has nothing below it: re-read the same tile rather than wrap.
    row_below = last_row ? row_snap : row_snap + idx_t'(1);
  end

  always_comb begin
    out_of_range = (chef_x_snap > X_LIMIT) || (chef_y_snap > Y_LIMIT);
    below_ladder = last_row ? 1'b0 : map_data[TILE_LADDER_BIT];
    walk_next    = ~out_of_range & cur_tile[TILE_FLOOR_BIT] &
                   (chef_y_snap[2:0] == WALK_ALIGN);
    climb_next   = ~out_of_range & (cur_tile[TILE_LADDER_BIT] | below_ladder) &
                   (chef_x_snap[2:0] == CLIMB_ALIGN);
  end

  // Outputs are registered alongside the state so each phase shows up exactly
  // one cycle after the transition that selects it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      walk        <= 1'b0;
      climb       <= 1'b0;
      busy        <= 1'b0;
      map_rd      <= 1'b0;
      map_addr    <= '0;
      chef_x_snap <= '0;
      chef_y_snap <= '0;
      row_snap    <= '0;
      col_snap    <= '0;
      cur_tile    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (edge_pulse) begin
            chef_x_snap <= ChefX;
            chef_y_snap <= ChefY;
            row_snap    <= row_now;
            col_snap    <= col_now;
            map_addr    <= {row_now, col_now};
            map_rd      <= 1'b1;
            busy        <= 1'b1;
            state       <= RD_CUR;
          end
        end
        RD_CUR: begin
          map_addr <= {row_below, col_snap};
          state    <= RD_BELOW;
        end
        RD_BELOW: begin
          cur_tile <= map_data;
          map_rd   <= 1'b0;
          state    <= RESOLVE;
        end
        RESOLVE: begin
          walk  <= walk_next;
          climb <= climb_next;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nav_map_checker.sv
// Directed bench for nav_map_checker with a per-cycle reference model and a
// synchronous map ROM.
module tb_nav_map_checker;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic [9:0] ChefX;
  logic [9:0] ChefY;
  logic [9:0] map_addr;
  logic       map_rd;
  logic [1:0] map_data;
  logic       walk;
  logic       climb;
  logic       busy;

  nav_map_checker dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .ChefX     (ChefX),
    .ChefY     (ChefY),
    .map_addr  (map_addr),
    .map_rd    (map_rd),
    .map_data  (map_data),
    .walk      (walk),
    .climb     (climb),
    .busy      (busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  logic [1:0] map_mem [1024];

  always @(posedge Clk) map_data <= map_mem[map_addr];

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned rd_pulses = 0;
  bit          check_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted frame edge is resolved at once from the map,
  // then played out on a fixed per-evaluation timeline.
  int unsigned cyc = 0;
  int unsigned pend[$];
  bit          f_prev = 0;
  bit          active = 0;
  int unsigned e_start = 0;
  logic        m_walk = 0, m_climb = 0, m_busy = 0, m_rd = 0;
  logic [9:0]  m_addr = 0, m_a1 = 0, m_a2 = 0;
  logic        m_rw = 0, m_rc = 0;

  always @(posedge Clk) begin
    int row, col, cur, below, xa, ya;
    bit in_range;
    cyc++;
    if (Reset) begin
      pend.delete();
      f_prev  = 0;
      active  = 0;
      m_walk  = 0;
      m_climb = 0;
      m_busy  = 0;
      m_rd    = 0;
      m_addr  = 0;
    end else begin
      // A rise seen at this edge is acted on three edges later.
      if (frame_clk && !f_prev) pend.push_back(cyc + 3);
      f_prev = frame_clk;
      if (pend.size() > 0 && pend[0] == cyc) begin
        void'(pend.pop_front());
        if (!active) begin
          xa = int'(ChefX);
          ya = int'(ChefY);
          row = (ya / 8) % 32;
          col = (xa / 8) % 32;
          m_a1 = 10'(row * 32 + col);
          m_a2 = (row == 31) ? m_a1 : 10'((row + 1) * 32 + col);
          cur   = int'(map_mem[m_a1]);
          below = (row == 31) ? 0 : int'(map_mem[m_a2]);
          in_range = (xa <= 192) && (ya <= 148);
          m_rw = in_range && (cur % 2 == 1) && (ya % 8 == 0);
          m_rc = in_range && ((cur / 2 == 1) || (below / 2 == 1)) && (xa % 8 == 0);
          active  = 1;
          e_start = cyc;
        end
      end
      if (active) begin
        case (cyc - e_start)
          0: begin m_rd = 1; m_busy = 1; m_addr = m_a1; end
          1: m_addr = m_a2;
          2: m_rd = 0;
          default: begin
            m_busy  = 0;
            m_walk  = m_rw;
            m_climb = m_rc;
            active  = 0;
          end
        endcase
      end
    end
  end

  always @(negedge Clk) begin
    if (map_rd === 1'b1) rd_pulses++;
    if (check_en) begin
      check("cyc_walk", 32'(walk), 32'(m_walk));
      check("cyc_climb", 32'(climb), 32'(m_climb));
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_map_rd", 32'(map_rd), 32'(m_rd));
      if (m_rd) check("cyc_map_addr", 32'(map_addr), 32'(m_addr));
    end
  end

  task automatic eval(input string name, input logic [9:0] x, input logic [9:0] y,
                      input logic [9:0] a1, input logic [9:0] a2,
                      input logic ew, input logic ec);
    bit seen;
    int unsigned rd0;
    @(negedge Clk);
    ChefX = x;
    ChefY = y;
    frame_clk = 1'b1;
    rd0 = rd_pulses;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge Clk);
      seen = (busy === 1'b1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_busy_timeout: busy stayed 0 for 10 cycles, expected 1", name);
    end else begin
      check({name, "_addr_cur"}, 32'(map_addr), 32'(a1));
      check({name, "_rd_cur"}, 32'(map_rd), 32'd1);
      // Moving the chef mid-evaluation must not matter.
      ChefX = x ^ 10'h155;
      ChefY = y ^ 10'h0AA;
      frame_clk = 1'b0;
      @(negedge Clk);
      check({name, "_addr_below"}, 32'(map_addr), 32'(a2));
      check({name, "_rd_below"}, 32'(map_rd), 32'd1);
      @(negedge Clk);
      check({name, "_rd_resolve"}, 32'(map_rd), 32'd0);
      check({name, "_busy_resolve"}, 32'(busy), 32'd1);
      @(negedge Clk);
      check({name, "_walk"}, 32'(walk), 32'(ew));
      check({name, "_climb"}, 32'(climb), 32'(ec));
      check({name, "_busy_done"}, 32'(busy), 32'd0);
    end
    frame_clk = 1'b0;
    repeat (6) @(negedge Clk);
    check({name, "_rd_pulses"}, rd_pulses - rd0, 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned rd0;
    for (int i = 0; i < 1024; i++) map_mem[i] = 2'b00;
    Reset = 1'b1;
    frame_clk = 1'b0;
    ChefX = '0;
    ChefY = '0;
    repeat (3) @(negedge Clk);
    check("reset_walk", 32'(walk), 32'd0);
    check("reset_climb", 32'(climb), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_map_rd", 32'(map_rd), 32'd0);
    check("reset_map_addr", 32'(map_addr), 32'd0);
    Reset = 1'b0;
    check_en = 1;
    repeat (2) @(negedge Clk);

    map_mem[18*32+12] = 2'b01;
    eval("floor", 10'd96, 10'd144, 10'h24C, 10'h26C, 1'b1, 1'b0);

    map_mem[17*32+12] = 2'b00;
    map_mem[18*32+12] = 2'b10;
    eval("ladder_below", 10'd96, 10'd136, 10'h22C, 10'h24C, 1'b0, 1'b1);
    eval("misalign_x", 10'd97, 10'd136, 10'h22C, 10'h24C, 1'b0, 1'b0);

    map_mem[17*32+12] = 2'b01;
    eval("floor_ladder", 10'd96, 10'd136, 10'h22C, 10'h24C, 1'b1, 1'b1);
    eval("misalign_y", 10'd96, 10'd137, 10'h22C, 10'h24C, 1'b0, 1'b1);

    map_mem[17*32+25] = 2'b11;
    eval("x_limit", 10'd200, 10'd136, 10'h239, 10'h259, 1'b0, 1'b0);

    map_mem[18*32+12] = 2'b01;
    eval("floor_again", 10'd96, 10'd144, 10'h24C, 10'h26C, 1'b1, 1'b0);

    map_mem[31*32+12] = 2'b11;
    eval("row31_ylimit", 10'd96, 10'd250, 10'h3EC, 10'h3EC, 1'b0, 1'b0);

    // Abort an evaluation with Reset two cycles in.
    eval("pre_reset", 10'd96, 10'd144, 10'h24C, 10'h26C, 1'b1, 1'b0);
    @(negedge Clk);
    frame_clk = 1'b1;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge Clk);
        seen = (busy === 1'b1);
      end
      check("abort_busy_started", 32'(seen), 32'd1);
    end
    @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_walk", 32'(walk), 32'd0);
    check("abort_climb", 32'(climb), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_map_rd", 32'(map_rd), 32'd0);
    check("abort_map_addr", 32'(map_addr), 32'd0);
    repeat (5) @(negedge Clk);
    check("abort_no_update_walk", 32'(walk), 32'd0);
    check("abort_no_update_busy", 32'(busy), 32'd0);

    // Second edge lands while busy; a later one starts a fresh evaluation.
    @(negedge Clk);
    ChefX = 10'd96;
    ChefY = 10'd144;
    frame_clk = 1'b1;
    rd0 = rd_pulses;
    @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (5) @(negedge Clk);
    check("overlap_first_rd_pulses", rd_pulses - rd0, 32'd2);
    check("overlap_first_walk", 32'(walk), 32'd1);
    map_mem[18*32+12] = 2'b10;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (10) @(negedge Clk);
    check("overlap_total_rd_pulses", rd_pulses - rd0, 32'd4);
    check("overlap_fresh_walk", 32'(walk), 32'd0);
    check("overlap_fresh_climb", 32'(climb), 32'd1);

    check_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
